// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard scoreboard.
//   REG_W_DEF   : default register address width
//   REG_W_MAX   : widest register address an entry can hold (dest zero-extended)
//   FWD_REGFILE : forwarding select meaning "take the register-file value"
//   entry_t     : one tracked in-flight instruction {valid, dest, is_load}
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_W_DEF   = 5;
    localparam int REG_W_MAX   = 16;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] dest;
        logic                 is_load;
    } entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// ID-stage request and EX-stage response bundle for the hazard scoreboard.
//   master : pipeline control side (drives hold/flush and the ID instruction)
//   slave  : scoreboard side (returns stall and registered EX forwarding info)
// Signals: hold, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
//          id_reg_write, id_is_load -> ; <- stall, ex_fwd_a, ex_fwd_b, ex_valid
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int SEL_W = 2
);
    logic             hold;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic             stall;
    logic [SEL_W-1:0] ex_fwd_a;
    logic [SEL_W-1:0] ex_fwd_b;
    logic             ex_valid;

    modport master (
        output hold, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_reg_write, id_is_load,
        input  stall, ex_fwd_a, ex_fwd_b, ex_valid
    );

    modport slave (
        input  hold, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_reg_write, id_is_load,
        output stall, ex_fwd_a, ex_fwd_b, ex_valid
    );

endinterface

// File: rtl/hazard_src_match.sv
// -----------------------------------------------------------------------------
// hazard_src_match
// Combinational youngest-match priority encoder for one source operand.
//   i_ent     : tracked entries, index 0 = EX (youngest)
//   i_src     : source register (zero-extended)
//   i_used    : source is actually read
//   o_hit     : some valid entry writes i_src (register 0 never hits)
//   o_pos     : EX-time position k+1 of the youngest matching entry
//   o_is_load : youngest matching entry is a load
// -----------------------------------------------------------------------------
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int POS_W = 2
) (
    input  entry_t [DEPTH-1:0]     i_ent,
    input  logic   [REG_W_MAX-1:0] i_src,
    input  logic                   i_used,
    output logic                   o_hit,
    output logic   [POS_W-1:0]     o_pos,
    output logic                   o_is_load
);

    // Scan oldest to youngest so the lowest matching index is written last.
    always_comb begin
        o_hit     = 1'b0;
        o_pos     = '0;
        o_is_load = 1'b0;
        if (i_used && (i_src != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (i_ent[k].valid && (i_ent[k].dest == i_src)) begin
                    o_hit     = 1'b1;
                    o_pos     = POS_W'(k + 1);
                    o_is_load = i_ent[k].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks destinations of in-flight instructions (EX onward) and produces the
// load-use stall for ID plus registered per-operand forwarding selects for EX.
//   clk, rst  : clock, synchronous active-high reset (overrides hold/flush)
//   bus       : hazard_scoreboard_if.slave (ID request, stall, EX selects)
//   stall_cnt : saturating stall-cycle counter   (HAZARD_PERF_CNT_EN only)
//   fwd_cnt   : saturating forwarded-issue count (HAZARD_PERF_CNT_EN only)
// Select encoding: 0 = regfile, p = value from pipeline register at position p.
// Optional feature macro: HAZARD_PERF_CNT_EN
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int REG_W    = REG_W_DEF,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]         stall_cnt,
    output logic [31:0]         fwd_cnt,
`endif
    hazard_scoreboard_if.slave  bus
);

    // Position DEPTH never forwards but must still be representable.
    localparam int POS_W = $clog2(DEPTH + 1);

    entry_t [DEPTH-1:0] r_ent;
    logic   [SEL_W-1:0] r_fwd_a;
    logic   [SEL_W-1:0] r_fwd_b;
    logic               r_ex_valid;

    logic   [REG_W-1:0] w_rs;
    logic   [REG_W-1:0] w_rt;
    logic   [REG_W-1:0] w_rd;
    logic               w_a_hit, w_a_ld, w_b_hit, w_b_ld;
    logic   [POS_W-1:0] w_a_pos, w_b_pos;
    logic   [SEL_W-1:0] w_sel_a, w_sel_b;
    logic               w_a_lu, w_b_lu;
    logic               w_stall;
    logic               w_issue;
    entry_t             w_new;

    assign w_rs = bus.id_rs;
    assign w_rt = bus.id_rt;
    assign w_rd = bus.id_rd;

    hazard_src_match #(.DEPTH(DEPTH), .POS_W(POS_W)) u_match_rs (
        .i_ent     (r_ent),
        .i_src     (REG_W_MAX'(w_rs)),
        .i_used    (bus.id_rs_used),
        .o_hit     (w_a_hit),
        .o_pos     (w_a_pos),
        .o_is_load (w_a_ld)
    );

    hazard_src_match #(.DEPTH(DEPTH), .POS_W(POS_W)) u_match_rt (
        .i_ent     (r_ent),
        .i_src     (REG_W_MAX'(w_rt)),
        .i_used    (bus.id_rt_used),
        .o_hit     (w_b_hit),
        .o_pos     (w_b_pos),
        .o_is_load (w_b_ld)
    );

    // The last entry is written back this cycle; the regfile write-through
    // already supplies it, so only positions up to DEPTH-1 forward.
    assign w_sel_a = (w_a_hit && (w_a_pos <= POS_W'(DEPTH - 1))) ? SEL_W'(w_a_pos)
                                                                 : SEL_W'(FWD_REGFILE);
    assign w_sel_b = (w_b_hit && (w_b_pos <= POS_W'(DEPTH - 1))) ? SEL_W'(w_b_pos)
                                                                 : SEL_W'(FWD_REGFILE);

    // Load data is not available before position LOAD_LAT.
    assign w_a_lu  = w_a_hit && w_a_ld && (w_a_pos < POS_W'(LOAD_LAT));
    assign w_b_lu  = w_b_hit && w_b_ld && (w_b_pos < POS_W'(LOAD_LAT));

    // Flush beats stall; hold masks stall so the frozen pipe sees no bubble.
    assign w_stall = !bus.hold && bus.id_valid && !bus.flush && (w_a_lu || w_b_lu);
    assign w_issue = bus.id_valid && !w_stall && !bus.flush;

    assign w_new = '{valid:   w_issue && bus.id_reg_write,
                     dest:    REG_W_MAX'(w_rd),
                     is_load: bus.id_is_load};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent      <= '0;
            r_fwd_a    <= '0;
            r_fwd_b    <= '0;
            r_ex_valid <= 1'b0;
        end else if (!bus.hold) begin
            r_ent      <= {r_ent[DEPTH-2:0], w_new};
            r_fwd_a    <= w_issue ? w_sel_a : SEL_W'(FWD_REGFILE);
            r_fwd_b    <= w_issue ? w_sel_b : SEL_W'(FWD_REGFILE);
            r_ex_valid <= w_issue;
        end
    end

    assign bus.stall    = w_stall;
    assign bus.ex_fwd_a = r_fwd_a;
    assign bus.ex_fwd_b = r_fwd_b;
    assign bus.ex_valid = r_ex_valid;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!bus.hold) begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_issue && ((w_sel_a != '0) || (w_sel_b != '0)) && (r_fwd_cnt != '1))
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Table-driven bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=2). Each row is
// one ID cycle: stall is checked combinationally mid-cycle, and the expected EX
// outputs are queued and compared one clock later.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int DEPTH    = 3;
    localparam int REG_W    = 5;
    localparam int LOAD_LAT = 2;
    localparam int SEL_W    = 2;
    localparam int NV       = 25;

    typedef struct {
        logic hold, flush, v;
        int   rs;
        logic rsu;
        int   rt;
        logic rtu;
        int   rd;
        logic rw, ld;
        logic st, exv;
        int   fa, fb;
    } vec_t;

    typedef struct {
        logic exv;
        int   fa, fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    vec_t tbl[NV];

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    hazard_scoreboard_if #(.REG_W(REG_W), .SEL_W(SEL_W)) bus ();

    hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic h, input logic f, input logic v,
                                input int rs, input logic rsu, input int rt, input logic rtu,
                                input int rd, input logic rw, input logic ld,
                                input logic st, input logic exv, input int fa, input int fb);
        vec_t r;
        r.hold = h;  r.flush = f; r.v = v;
        r.rs = rs;   r.rsu = rsu; r.rt = rt; r.rtu = rtu;
        r.rd = rd;   r.rw = rw;   r.ld = ld;
        r.st = st;   r.exv = exv; r.fa = fa; r.fb = fb;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.hold         = v.hold;
        bus.flush        = v.flush;
        bus.id_valid     = v.v;
        bus.id_rs        = REG_W'(v.rs);
        bus.id_rs_used   = v.rsu;
        bus.id_rt        = REG_W'(v.rt);
        bus.id_rt_used   = v.rtu;
        bus.id_rd        = REG_W'(v.rd);
        bus.id_reg_write = v.rw;
        bus.id_is_load   = v.ld;
    endtask

    // One ID cycle: inputs applied just after a rising edge, stall sampled on
    // the falling edge, EX outputs compared #1 after the next rising edge.
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        drive(v);
        @(negedge clk);
        chk({nm, " stall"}, int'(bus.stall), int'(v.st));
        q.push_back('{exv: v.exv, fa: v.fa, fb: v.fb});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({nm, " queue"}, 0, 1);
        end else begin
            e = q.pop_front();
            chk({nm, " ex_valid"}, int'(bus.ex_valid), int'(e.exv));
            chk({nm, " ex_fwd_a"}, int'(bus.ex_fwd_a), e.fa);
            chk({nm, " ex_fwd_b"}, int'(bus.ex_fwd_b), e.fb);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int es = 0;
        int ef = 0;
        //               h f v  rs u  rt u  rd w l  st exv fa fb
        // ALU chain: back-to-back, one gap, two gaps
        tbl[0]  = mk(0,0,1,  1,1,  2,1,  3,1,0, 0,1,0,0);
        tbl[1]  = mk(0,0,1,  3,1,  3,1,  4,1,0, 0,1,1,1);
        tbl[2]  = mk(0,0,1,  3,1,  1,1,  5,1,0, 0,1,2,0);
        tbl[3]  = mk(0,0,1,  3,1,  4,1,  6,1,0, 0,1,0,2);
        // load-use: one stall cycle, then forward from position 2
        tbl[4]  = mk(0,0,1,  1,1,  0,0,  5,1,1, 0,1,0,0);
        tbl[5]  = mk(0,0,1,  5,1,  0,1,  6,1,0, 1,0,0,0);
        tbl[6]  = mk(0,0,1,  5,1,  0,1,  6,1,0, 0,1,2,0);
        // register 0 never matches; unused rt never matches
        tbl[7]  = mk(0,0,1,  1,1,  0,0,  0,1,1, 0,1,0,0);
        tbl[8]  = mk(0,0,1,  0,1,  0,1,  7,1,0, 0,1,0,0);
        tbl[9]  = mk(0,0,1,  1,1,  0,0,  8,1,1, 0,1,0,0);
        tbl[10] = mk(0,0,1,  2,1,  8,0,  9,1,0, 0,1,0,0);
        // youngest producer wins
        tbl[11] = mk(0,0,1,  1,1,  2,1,  7,1,0, 0,1,0,0);
        tbl[12] = mk(0,0,1,  1,1,  0,0,  7,1,0, 0,1,0,0);
        tbl[13] = mk(0,0,1,  7,1,  9,1, 10,1,0, 0,1,1,0);
        // flush on a would-be load-use stall
        tbl[14] = mk(0,0,1,  1,1,  0,0, 11,1,1, 0,1,0,0);
        tbl[15] = mk(0,1,1, 11,1,  0,1, 12,1,0, 0,0,0,0);
        tbl[16] = mk(0,0,1, 10,1, 11,1, 12,1,1, 0,1,0,2);
        // hold 3 cycles over a pending load-use: outputs frozen, no stall
        tbl[17] = mk(1,0,1, 12,1,  0,1, 13,1,0, 0,1,0,2);
        tbl[18] = mk(1,0,1, 12,1,  0,1, 13,1,0, 0,1,0,2);
        tbl[19] = mk(1,0,1, 12,1,  0,1, 13,1,0, 0,1,0,2);
        tbl[20] = mk(0,0,1, 12,1,  0,1, 13,1,0, 1,0,0,0);
        tbl[21] = mk(0,0,1, 12,1,  0,1, 13,1,0, 0,1,2,0);
        // idle ID, flushed writer never recorded
        tbl[22] = mk(0,0,0, 13,1,  0,0,  0,0,0, 0,0,0,0);
        tbl[23] = mk(0,1,1,  1,1,  0,0, 14,1,0, 0,0,0,0);
        tbl[24] = mk(0,0,1, 14,1, 13,1, 15,1,0, 0,1,0,0);

        rst = 1'b1;
        drive(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset ex_valid", int'(bus.ex_valid), 0);
        chk("reset ex_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("reset ex_fwd_b", int'(bus.ex_fwd_b), 0);
        chk("reset stall",    int'(bus.stall),    0);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i], $sformatf("row%0d", i));
            if (!tbl[i].hold && tbl[i].st) es++;
            if (!tbl[i].hold && tbl[i].exv && (tbl[i].fa != 0 || tbl[i].fb != 0)) ef++;
        end

`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", int'(stall_cnt), es);
        chk("fwd_cnt",   int'(fwd_cnt),   ef);
`endif

        // Reset mid-stream with hold asserted: reset must still clear state.
        step(mk(0,0,1, 15,1, 0,0, 20,1,1, 0,1,1,0), "lw_r20");
        drive(mk(1,0,1, 20,1, 0,1, 21,1,0, 0,0,0,0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.hold = 1'b0;
        chk("midrst ex_valid", int'(bus.ex_valid), 0);
        chk("midrst ex_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("midrst ex_fwd_b", int'(bus.ex_fwd_b), 0);
        chk("midrst stall",    int'(bus.stall),    0);
`ifdef HAZARD_PERF_CNT_EN
        chk("midrst stall_cnt", int'(stall_cnt), 0);
        chk("midrst fwd_cnt",   int'(fwd_cnt),   0);
`endif
        step(mk(0,0,1, 20,1, 0,1, 21,1,0, 0,1,0,0), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
